fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; power of two, 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: payload width per requester.
REQ-003 Parameter DEPTH, default 4: shared FIFO entries; power of two, >=2.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 Port io_in_valid  input  NUM_REQ  per-requester push request.
REQ-007 Port io_in_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port io_in_ready  output  NUM_REQ  per-requester accept; at most one bit set.
REQ-009 Port io_out_valid  output  1  FIFO non-empty.
REQ-010 Port io_out_data  output  DATA_WIDTH  head payload.
REQ-011 Port io_out_src  output  log2(NUM_REQ)  index of requester that pushed the head entry.
REQ-012 Port io_out_ready  input  1  consumer pop request.
REQ-013 Port io_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 Grant is combinational: first requester with io_in_valid set, searching upward from priority pointer ptr, wrapping NUM_REQ-1 -> 0.
REQ-015 io_in_ready[i] = (i == granted index) & io_in_valid[i] & !full; all zero when no valid or FIFO full.
REQ-016 Push occurs in the cycle io_in_valid[g] & io_in_ready[g]; {g, payload} written at write pointer, visible at head next cycle if FIFO was empty (1-cycle latency).
REQ-017 ptr updates only on a push: ptr <= (g+1) mod NUM_REQ; otherwise holds.
REQ-018 Pop occurs when io_out_valid & io_out_ready; read pointer advances; io_out_valid/io_out_data/io_out_src combinational from head entry.
REQ-019 io_out_ready while empty: no effect, pointers and count unchanged.
REQ-020 Read/write pointers log2(DEPTH)+1 bits; empty = pointers equal; full = low bits equal and MSB differ; wrap-around by natural overflow.
REQ-021 Push and pop in same cycle when 0<count<DEPTH: both happen, count unchanged.
REQ-022 When full, push blocked even if pop occurs that cycle (ready does not depend on io_out_ready).
REQ-023 When empty, simultaneous push and pop: push only; no bypass.
REQ-024 io_count = wr_ptr - rd_ptr (modulo 2^(log2(DEPTH)+1)); exact 0..DEPTH.
REQ-025 Data of non-granted requesters ignored; they hold io_in_valid until accepted (not checked by block).

Reset
REQ-026 While reset=0 at a rising edge: ptr<=0, wr_ptr<=0, rd_ptr<=0.
REQ-027 Post-reset outputs: io_out_valid=0, io_count=0, io_in_ready grants requester 0 priority, io_out_src/io_out_data don't-care (storage not cleared).
REQ-028 Reset mid-operation discards all stored entries; any push or pop in the reset cycle has no effect.

Structure
REQ-029 Shared package holds parameter defaults, clog2 helper, and entry record type {src, data}.
REQ-030 Storage + pointers in one sub-module, tagged_fifo (width log2(NUM_REQ)+DATA_WIDTH, depth DEPTH); arbitration and ptr in fifo_arbiter top.
REQ-031 Storage is a register array, write on push, asynchronous read at head.

Verification
REQ-032 Reset, then all requesters valid with data 0x10,0x11,0x12,0x13 held for 4 cycles, io_out_ready=0 -> grants 0,1,2,3 in order; io_count 1,2,3,4; io_in_ready all 0 on cycle 5.
REQ-033 From full, io_out_ready=1 four cycles -> io_out_src 0,1,2,3, io_out_data 0x10..0x13, io_count 3,2,1,0, io_out_valid=0 after.
REQ-034 Only requester 2 valid for 6 pushes with 1 pop/cycle -> every push granted to 2, io_count stays 1, pointers wrap past DEPTH with correct data order.
REQ-035 Full FIFO, requester 1 valid, io_out_ready=1 same cycle -> pop happens, io_in_ready[1]=0 that cycle, push accepted next cycle, io_count 4->3->4.
REQ-036 Two entries stored, ptr=3, reset=0 for one cycle with pushes pending -> io_count=0, io_out_valid=0, next grant to requester 0 when 0 and 3 both valid.

Source files
------------

// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated FIFO: parameter defaults,
// a constant-friendly log2 helper and the stored entry layout.
package fifo_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    localparam int DEF_SRC_WIDTH = clog2(DEF_NUM_REQ);

    // Each entry remembers which requester pushed it, packed above the payload.
    typedef struct packed {
        logic [DEF_SRC_WIDTH-1:0]  src;
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/tagged_fifo.sv
// Register-array FIFO with extra-MSB pointers; the head is read combinationally.
module tagged_fifo
    import fifo_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_SRC_WIDTH + DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    count
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        count   = wr_ptr_q - rd_ptr_q;
        rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
        do_push = push && !full;
        // Pop is gated on the pre-push state, so an empty FIFO never bypasses.
        do_pop  = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not cleared by reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter feeding a shared tagged FIFO; the winner's index is stored
// with its payload so the consumer knows where each entry came from.
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            io_in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] io_in_data,
    output logic [NUM_REQ-1:0]            io_in_ready,
    output logic                          io_out_valid,
    output logic [DATA_WIDTH-1:0]         io_out_data,
    output logic [clog2(NUM_REQ)-1:0]     io_out_src,
    input  logic                          io_out_ready,
    output logic [clog2(DEPTH):0]         io_count
);

    localparam int SRC_W   = clog2(NUM_REQ);
    localparam int ENTRY_W = SRC_W + DATA_WIDTH;

    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [SRC_W-1:0]      grant_idx;
    logic [SRC_W-1:0]      cand;
    logic                  grant_found;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  push;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ENTRY_W-1:0]    head;

    // Search upward from ptr; SRC_W-bit addition wraps because NUM_REQ is a power of two.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + SRC_W'(k);
            if (!grant_found && io_in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data  = '0;
        io_in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                grant_data     = io_in_data[i*DATA_WIDTH +: DATA_WIDTH];
                io_in_ready[i] = grant_found && !fifo_full;
            end
        end
        push  = |io_in_ready;
        ptr_d = push ? grant_idx + SRC_W'(1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    tagged_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ({grant_idx, grant_data}),
        .pop     (io_out_ready),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (io_count)
    );

    always_comb begin
        io_out_valid = !fifo_empty;
        io_out_src   = head[ENTRY_W-1 -: SRC_W];
        io_out_data  = head[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed self-checking bench for fifo_arbiter with default parameters.
module tb_fifo_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  io_in_valid;
    logic [31:0] io_in_data;
    logic [3:0]  io_in_ready;
    logic        io_out_valid;
    logic [7:0]  io_out_data;
    logic [1:0]  io_out_src;
    logic        io_out_ready;
    logic [2:0]  io_count;

    int checks;
    int failures;

    fifo_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_data   (io_in_data),
        .io_in_ready  (io_in_ready),
        .io_out_valid (io_out_valid),
        .io_out_data  (io_out_data),
        .io_out_src   (io_out_src),
        .io_out_ready (io_out_ready),
        .io_count     (io_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then let combinational outputs settle before any check.
    task automatic applyStimulus(input logic rst_n, input logic [3:0] valid,
                                 input logic [31:0] data, input logic out_ready);
        reset        = rst_n;
        io_in_valid  = valid;
        io_in_data   = data;
        io_out_ready = out_ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
        checkOutput("reset_count", 32'(io_count), 32'd0);
        checkOutput("reset_out_valid", 32'(io_out_valid), 32'd0);
        checkOutput("reset_ready_idle", 32'(io_in_ready), 32'd0);

        // All requesters valid: round-robin fills the FIFO in order 0..3.
        applyStimulus(1'b1, 4'b1111, 32'h13121110, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fill_ready_%0d", i), 32'(io_in_ready), 32'(1 << i));
            tick();
            checkOutput($sformatf("fill_count_%0d", i), 32'(io_count), 32'(i + 1));
            checkOutput($sformatf("fill_head_src_%0d", i), 32'(io_out_src), 32'd0);
        end
        checkOutput("full_ready_blocked", 32'(io_in_ready), 32'd0);
        checkOutput("full_out_valid", 32'(io_out_valid), 32'd1);

        // Drain in arrival order.
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_src_%0d", i), 32'(io_out_src), 32'(i));
            checkOutput($sformatf("drain_data_%0d", i), 32'(io_out_data), 32'(8'h10 + i));
            tick();
            checkOutput($sformatf("drain_count_%0d", i), 32'(io_count), 32'(3 - i));
        end
        checkOutput("drained_out_valid", 32'(io_out_valid), 32'd0);
        tick();
        checkOutput("empty_pop_count", 32'(io_count), 32'd0);

        // Requester 2 alone, streaming with one pop per cycle; pointers wrap.
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b1, 4'b0100, {8'h00, 8'(8'h20 + n), 16'h0000}, 1'b1);
            checkOutput($sformatf("stream_ready_%0d", n), 32'(io_in_ready), 32'b0100);
            if (n > 0) begin
                checkOutput($sformatf("stream_data_%0d", n), 32'(io_out_data), 32'(8'h20 + n - 1));
                checkOutput($sformatf("stream_src_%0d", n), 32'(io_out_src), 32'd2);
            end
            tick();
            checkOutput($sformatf("stream_count_%0d", n), 32'(io_count), 32'd1);
        end
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
        checkOutput("stream_last_data", 32'(io_out_data), 32'h25);
        tick();
        checkOutput("stream_end_count", 32'(io_count), 32'd0);

        // Refill from ptr=3: grants go 3,0,1,2.
        applyStimulus(1'b1, 4'b1111, 32'h13121110, 1'b0);
        checkOutput("refill_first_grant", 32'(io_in_ready), 32'b1000);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("refill_count", 32'(io_count), 32'd4);
        checkOutput("refill_head_src", 32'(io_out_src), 32'd3);
        checkOutput("refill_head_data", 32'(io_out_data), 32'h13);

        // Full with a pop in the same cycle: push still blocked this cycle.
        applyStimulus(1'b1, 4'b0010, 32'h00003100, 1'b1);
        checkOutput("full_pop_ready", 32'(io_in_ready), 32'd0);
        tick();
        checkOutput("full_pop_count", 32'(io_count), 32'd3);
        applyStimulus(1'b1, 4'b0010, 32'h00003100, 1'b0);
        checkOutput("after_pop_ready", 32'(io_in_ready), 32'b0010);
        tick();
        checkOutput("after_pop_count", 32'(io_count), 32'd4);

        // Drain, then store two entries from requester 2 leaving ptr=3.
        applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("predrain_count", 32'(io_count), 32'd0);
        applyStimulus(1'b1, 4'b0100, 32'h00400000, 1'b0);
        tick();
        checkOutput("two_first_ready", 32'(io_in_ready), 32'b0100);
        tick();
        checkOutput("two_count", 32'(io_count), 32'd2);

        // Reset mid-operation with requests pending.
        applyStimulus(1'b0, 4'b1001, 32'h50000060, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b1001, 32'h50000060, 1'b0);
        checkOutput("midreset_count", 32'(io_count), 32'd0);
        checkOutput("midreset_out_valid", 32'(io_out_valid), 32'd0);
        checkOutput("midreset_grant", 32'(io_in_ready), 32'b0001);
        tick();
        checkOutput("postreset_count", 32'(io_count), 32'd1);
        checkOutput("postreset_src", 32'(io_out_src), 32'd0);
        checkOutput("postreset_data", 32'(io_out_data), 32'h60);
        checkOutput("postreset_next_grant", 32'(io_in_ready), 32'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
